// File: rtl/cpu_pkg.sv
// Shared decode constants, field layout and skid-stage state encoding.
// Imported by the IF/ID stage and later pipeline stages.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNC_LSB   = 0;
   localparam int IMM16_LSB  = 0;

   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int FUNC_W   = 6;
   localparam int IMM16_W  = 16;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_W-1:0]    rs;
      logic [REG_W-1:0]    rt;
      logic [REG_W-1:0]    rd;
      logic [REG_W-1:0]    shamt;
      logic [FUNC_W-1:0]   func;
      logic [IMM16_W-1:0]  imm16;
   } dec_t;

   function automatic dec_t decode_fields(input logic [31:0] w);
      dec_t d;
      d.opcode = w[OPCODE_LSB +: OPCODE_W];
      d.rs     = w[RS_LSB     +: REG_W];
      d.rt     = w[RT_LSB     +: REG_W];
      d.rd     = w[RD_LSB     +: REG_W];
      d.shamt  = w[SHAMT_LSB  +: REG_W];
      d.func   = w[FUNC_LSB   +: FUNC_W];
      d.imm16  = w[IMM16_LSB  +: IMM16_W];
      return d;
   endfunction

   // Logical immediates are unsigned; everything else sign-extends.
   function automatic logic is_zero_ext(input logic [OPCODE_W-1:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/imm_extender.sv
// Immediate extender: 16-bit immediate to IMM_W, zero- or sign-extended by opcode.
// Latency 0 (combinational); no handshake, so no backpressure.
module imm_extender
   import cpu_pkg::*;
#(
   parameter int IMM_W = 32
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [IMM16_W-1:0]  imm,
   output logic [IMM_W-1:0]    imm_ext
);

   if (IMM_W < 16) begin : g_bad_imm_w
      $error("imm_extender: IMM_W must be at least 16");
   end

   always_comb begin
      imm_ext = IMM_W'($signed(imm));
      if (is_zero_ext(opcode)) begin
         imm_ext = IMM_W'(imm);
      end
   end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID two-entry skid register with decode; latency 1 cycle in to out_valid.
// Backpressure: in_ready is registered and drops only when both entries are full.
module if_id_skid_reg
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int IMM_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [5:0]         opcode,
   output logic [5:0]         func,
   output logic [4:0]         rs,
   output logic [4:0]         rt,
   output logic [4:0]         rd,
   output logic [4:0]         shamt,
   output logic [15:0]        jump_address,
   output logic [PC_W-1:0]    out_pc,
   output logic [IMM_W-1:0]   imm_ext
);

   if (INSTR_W != 32) begin : g_bad_instr_w
      $error("if_id_skid_reg: INSTR_W must be 32 for the fixed field layout");
   end

   skid_state_t        state_q, state_d;
   logic               in_ready_q;
   logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
   logic [PC_W-1:0]    main_pc_q, skid_pc_q;
   logic               in_xfer, out_xfer;
   logic               load_main_in, load_main_skid, load_skid;
   dec_t               dec;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign in_xfer   = in_valid && in_ready_q;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  load_main_in = 1'b1;
                  state_d      = ST_ONE;
               end
            end
            ST_ONE: begin
               case ({in_xfer, out_xfer})
                  2'b11: load_main_in = 1'b1;
                  2'b10: begin
                     load_skid = 1'b1;
                     state_d   = ST_TWO;
                  end
                  2'b01: state_d = ST_EMPTY;
                  default: state_d = ST_ONE;
               endcase
            end
            ST_TWO: begin
               // in_ready is low here, so only the drain side can move.
               if (out_xfer) begin
                  load_main_skid = 1'b1;
                  state_d        = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
      end
   end

   // Payload is not cleared on flush; out_valid alone marks it stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_instr_q <= '0;
         main_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         if (load_main_in) begin
            main_instr_q <= instruction;
            main_pc_q    <= in_pc;
         end else if (load_main_skid) begin
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
         end
         if (load_skid) begin
            skid_instr_q <= instruction;
            skid_pc_q    <= in_pc;
         end
      end
   end

   assign dec          = decode_fields(main_instr_q[31:0]);
   assign opcode       = dec.opcode;
   assign func         = dec.func;
   assign rs           = dec.rs;
   assign rt           = dec.rt;
   assign rd           = dec.rd;
   assign shamt        = dec.shamt;
   assign jump_address = dec.imm16;
   assign out_pc       = main_pc_q;

   imm_extender #(
      .IMM_W (IMM_W)
   ) u_imm_extender (
      .opcode  (dec.opcode),
      .imm     (dec.imm16),
      .imm_ext (imm_ext)
   );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: directed vectors, queue of expected entries.
module tb_if_id_skid_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  opcode, func;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] jump_address;
   logic [31:0] out_pc;
   logic [31:0] imm_ext;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;

   if_id_skid_reg #(.INSTR_W(32), .PC_W(32), .IMM_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .instruction  (instruction),
      .in_pc        (in_pc),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .opcode       (opcode),
      .func         (func),
      .rs           (rs),
      .rt           (rt),
      .rd           (rd),
      .shamt        (shamt),
      .jump_address (jump_address),
      .out_pc       (out_pc),
      .imm_ext      (imm_ext)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [111:0] got, input logic [111:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [111:0] dut_fields();
      return {opcode, rs, rt, rd, shamt, func, jump_address, out_pc, imm_ext};
   endfunction

   function automatic logic [111:0] exp_fields(input exp_t e);
      return {e.instr[31:26], e.instr[25:21], e.instr[20:16], e.instr[15:11],
              e.instr[10:6], e.instr[5:0], e.instr[15:0], e.pc, e.imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word; it is expected downstream only once in_ready accepts it.
   task automatic push(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] imm);
      bit done = 0;
      in_valid    = 1'b1;
      instruction = w;
      in_pc       = pc;
      for (int t = 0; t < 20 && !done; t++) begin
         if (in_ready) begin
            sb.push_back('{instr: w, pc: pc, imm: imm});
            done = 1;
         end
         step();
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL push_timeout got=in_ready_low expected=accept of %h", w);
      end
   endtask

   // Monitor: every out transfer must match the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            pops++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out got=%h expected=no_output", dut_fields());
            end else begin
               e = sb.pop_front();
               chk("out_entry", dut_fields(), exp_fields(e));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] sw [8];
   logic [31:0] si [8];

   initial begin
      int p0;
      sw = '{32'h2001_0001, 32'h3402_FFFF, 32'h2003_FFFF, 32'h3004_8000,
             32'h3805_7FFF, 32'h0000_0020, 32'h3C06_8001, 32'h2C07_8000};
      si = '{32'h0000_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_8000,
             32'h0000_7FFF, 32'h0000_0020, 32'hFFFF_8001, 32'hFFFF_8000};

      rst = 1'b1; in_valid = 1'b0; instruction = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
      step(); step();
      chk("reset_out_valid", 112'(out_valid), 112'(0));
      chk("reset_in_ready", 112'(in_ready), 112'(1));
      chk("reset_fields", dut_fields(), 112'(0));
      rst = 1'b0;
      step();

      // First word: lw, one-cycle latency.
      out_ready = 1'b1;
      push(32'h8C22_FFFC, 32'h0000_0100, 32'hFFFF_FFFC);
      chk("latency_out_valid", 112'(out_valid), 112'(1));
      chk("lw_fields", {opcode, rs, rt, out_pc, imm_ext}, {6'h23, 5'd1, 5'd2, 32'h100, 32'hFFFF_FFFC});
      step();

      push(32'h3422_8000, 32'h0000_0104, 32'h0000_8000);
      push(32'h2022_8000, 32'h0000_0108, 32'hFFFF_8000);
      step(); step();
      chk("drain_basic", 112'(sb.size()), 112'(0));

      // Backpressure: A then B fill both entries.
      out_ready = 1'b0;
      push(32'h3000_F00F, 32'h0000_0200, 32'h0000_F00F);
      push(32'h3800_8001, 32'h0000_0204, 32'h0000_8001);
      chk("full_in_ready", 112'(in_ready), 112'(0));
      for (int i = 0; i < 3; i++) begin
         chk("hold_stable", {opcode, out_pc, imm_ext}, {6'h0C, 32'h200, 32'h0000_F00F});
         step();
      end
      out_ready = 1'b1;
      step(); step(); step();
      chk("drain_ab", 112'(sb.size()), 112'(0));

      // Flush in TWO with a word offered: nothing survives.
      out_ready = 1'b0;
      push(32'h2011_1111, 32'h0000_0300, 32'h0000_1111);
      push(32'h2012_2222, 32'h0000_0304, 32'h0000_2222);
      flush = 1'b1; in_valid = 1'b1; instruction = 32'h2013_3333; in_pc = 32'h308;
      step();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("flush_two_out_valid", 112'(out_valid), 112'(0));
      chk("flush_two_in_ready", 112'(in_ready), 112'(1));
      out_ready = 1'b1;
      step(); step();

      // Flush in ONE: coincident in transfer must be dropped.
      out_ready = 1'b0;
      push(32'h2014_4444, 32'h0000_0400, 32'h0000_4444);
      flush = 1'b1; in_valid = 1'b1; instruction = 32'h2015_5555; in_pc = 32'h404;
      step();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("flush_one_out_valid", 112'(out_valid), 112'(0));
      out_ready = 1'b1;
      step(); step();

      // Sustained stream of 8 words.
      p0 = pops;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; instruction = sw[i]; in_pc = 32'h500 + 32'(4 * i);
         chk("stream_in_ready", 112'(in_ready), 112'(1));
         if (in_ready) sb.push_back('{instr: sw[i], pc: 32'h500 + 32'(4 * i), imm: si[i]});
         if (i > 0) chk("stream_out_valid", 112'(out_valid), 112'(1));
         step();
      end
      in_valid = 1'b0;
      chk("stream_last_valid", 112'(out_valid), 112'(1));
      step();
      chk("stream_pops", 112'(pops - p0), 112'(8));
      chk("stream_drain", 112'(sb.size()), 112'(0));

      // Asynchronous reset while in TWO.
      out_ready = 1'b0;
      push(32'h2016_6666, 32'h0000_0600, 32'h0000_6666);
      push(32'h2017_7777, 32'h0000_0604, 32'h0000_7777);
      #3 rst = 1'b1;
      #1;
      chk("arst_out_valid", 112'(out_valid), 112'(0));
      chk("arst_in_ready", 112'(in_ready), 112'(1));
      chk("arst_fields", dut_fields(), 112'(0));
      sb.delete();
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      push(32'h8C22_0010, 32'h0000_0700, 32'h0000_0010);
      step(); step();
      chk("final_drain", 112'(sb.size()), 112'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
